// File: rtl/mul_unit_pkg.sv
// Shared constants for the RV32M iterative multiplier: funct3 codes, ALUop
// multiply code and FSM state encoding.
package mul_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALUOP_MUL = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_operand_prep.sv
// Combinational sign handling for the multiplier: operand magnitudes on the way
// in, conditional two's-complement negate of the unsigned product on the way out.
module mul_operand_prep #(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   x1,
    input  logic [XLEN-1:0]   x2,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              negate,
    input  logic [2*XLEN-1:0] product_mag,
    input  logic              product_negate,
    output logic [2*XLEN-1:0] product
);
    import mul_unit_pkg::*;

    logic a_signed;
    logic b_signed;
    logic a_neg;
    logic b_neg;

    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
        b_signed = (funct3 == F3_MULH);
        a_neg    = a_signed && x1[XLEN-1];
        b_neg    = b_signed && x2[XLEN-1];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned 2^31
        mag_a    = a_neg ? -x1 : x1;
        mag_b    = b_neg ? -x2 : x2;
        negate   = a_neg ^ b_neg;
        product  = product_negate ? -product_mag : product_mag;
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add RV32M multiplier for the EX stage. Retires
// BITS_PER_CYCLE multiplier bits per RUN cycle and pulses done with the result.
module mul_unit #(
    parameter int XLEN           = mul_unit_pkg::XLEN,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] x1,
    input  logic [XLEN-1:0] x2,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import mul_unit_pkg::*;

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t              state_reg;
    logic [CNT_W-1:0]    counter_reg;
    logic [2*XLEN-1:0]   acc_reg;
    logic [2*XLEN-1:0]   acc_next;
    logic [2*XLEN-1:0]   mcand_reg;
    logic [XLEN-1:0]     mplier_reg;
    logic [2:0]          funct3_reg;
    logic                negate_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [XLEN-1:0]     result_reg;
    logic [XLEN-1:0]     result_next;

    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                negate;
    logic [2*XLEN-1:0]   product;
    logic [2*XLEN-1:0]   pp [BITS_PER_CYCLE];

    mul_operand_prep #(
        .XLEN(XLEN)
    ) u_prep (
        .funct3         (funct3),
        .x1             (x1),
        .x2             (x2),
        .mag_a          (mag_a),
        .mag_b          (mag_b),
        .negate         (negate),
        .product_mag    (acc_next),
        .product_negate (negate_reg),
        .product        (product)
    );

    // Partial products for the multiplier bits retired this cycle
    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            acc_next = acc_next + pp[i];
        end
        result_next = (funct3_reg == F3_MUL) ? product[XLEN-1:0]
                                             : product[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            funct3_reg  <= '0;
            negate_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
        end else if (flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        if (!funct3[2]) begin
                            mcand_reg   <= {{XLEN{1'b0}}, mag_a};
                            mplier_reg  <= mag_b;
                            funct3_reg  <= funct3;
                            negate_reg  <= negate;
                            acc_reg     <= '0;
                            counter_reg <= '0;
                            busy_reg    <= 1'b1;
                            state_reg   <= ST_RUN;
                        end else begin
                            result_reg <= '0;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    acc_reg     <= acc_next;
                    mcand_reg   <= mcand_reg << BITS_PER_CYCLE;
                    mplier_reg  <= mplier_reg >> BITS_PER_CYCLE;
                    counter_reg <= counter_reg + CNT_W'(1);
                    if (counter_reg == CNT_W'(N - 1)) begin
                        result_reg <= result_next;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Depends only on inputs and the state register, never on same-cycle updates
    assign stall  = start && !flush && (state_reg != ST_DONE);
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit: one instance retiring 1 bit per cycle and
// one retiring 4, with hand-computed products, latencies and control cases.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1;
    logic        start4;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        busy1, stall1, done1;
    logic [31:0] result1;
    logic        busy4, stall4, done4;
    logic [31:0] result4;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .flush(flush), .funct3(funct3),
        .x1(x1), .x2(x2), .busy(busy1), .stall(stall1), .done(done1), .result(result1)
    );

    mul_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .flush(flush), .funct3(funct3),
        .x1(x1), .x2(x2), .busy(busy4), .stall(stall4), .done(done4), .result(result4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 4) ? done4 : done1;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 4) ? busy4 : busy1;
    endfunction
    function automatic logic get_stall(input int sel);
        return (sel == 4) ? stall4 : stall1;
    endfunction
    function automatic logic [31:0] get_result(input int sel);
        return (sel == 4) ? result4 : result1;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 4) start4 = v;
        else          start1 = v;
    endtask

    // Waits (bounded) for done; returns stall/busy cycle counts seen before it
    task automatic wait_done(input int sel, output bit seen, output int stall_n,
                             output int busy_n, output int at_cyc,
                             input bit chg, input logic [31:0] ca, input logic [31:0] cb);
        seen = 0; stall_n = 0; busy_n = 0; at_cyc = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (chg && i == 5) begin
                x1 = ca;
                x2 = cb;
            end
            if (get_done(sel)) begin
                seen   = 1;
                at_cyc = cyc;
            end else begin
                if (get_stall(sel)) stall_n++;
                if (get_busy(sel))  busy_n++;
            end
        end
    endtask

    task automatic run_op(input int sel, input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_stall, input int exp_busy,
                          input bit chg, input logic [31:0] ca, input logic [31:0] cb);
        bit seen;
        int stall_n, busy_n, at_cyc;
        @(posedge clk); #1;
        funct3 = f3; x1 = a; x2 = b;
        set_start(sel, 1'b1);
        wait_done(sel, seen, stall_n, busy_n, at_cyc, chg, ca, cb);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_stall_cycles"}, stall_n, exp_stall);
        check({tag, "_busy_cycles"}, busy_n, exp_busy);
        check({tag, "_result"}, get_result(sel), exp_res);
        check({tag, "_stall_in_done"}, 32'(get_stall(sel)), 32'd0);
        $display("[TB] %s f3=%b x1=%08h x2=%08h -> result=%08h stall_cycles=%0d",
                 tag, f3, a, b, get_result(sel), stall_n);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        @(negedge clk);
        check({tag, "_done_single"}, 32'(get_done(sel)), 32'd0);
        check({tag, "_busy_after"}, 32'(get_busy(sel)), 32'd0);
    endtask

    task automatic back_to_back(input int sel, input string tag, input int exp_gap);
        bit seen;
        int stall_n, busy_n, t1, t2;
        @(posedge clk); #1;
        funct3 = 3'b000; x1 = 32'd2; x2 = 32'd3;
        set_start(sel, 1'b1);
        wait_done(sel, seen, stall_n, busy_n, t1, 1'b0, '0, '0);
        check({tag, "_first_seen"}, 32'(seen), 32'd1);
        check({tag, "_first_result"}, get_result(sel), 32'd6);
        @(posedge clk); #1;
        funct3 = 3'b011; x1 = 32'h0001_0000; x2 = 32'h0001_0000;
        wait_done(sel, seen, stall_n, busy_n, t2, 1'b0, '0, '0);
        check({tag, "_second_seen"}, 32'(seen), 32'd1);
        check({tag, "_second_result"}, get_result(sel), 32'h0000_0001);
        check({tag, "_done_gap"}, t2 - t1, exp_gap);
        $display("[TB] %s back-to-back results 6 then %08h gap=%0d", tag, get_result(sel), t2 - t1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0; flush = 1'b0;
        funct3 = 3'b000; x1 = '0; x2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_result", result1, 32'd0);
        check("rst_stall", 32'(stall1), 32'd0);
        $display("[TB] reset state checked");

        run_op(1, "mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32, 1'b0, '0, '0);
        run_op(1, "mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32, 1'b0, '0, '0);
        run_op(1, "mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32, 1'b0, '0, '0);
        run_op(1, "mulhsu_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32, 1'b0, '0, '0);

        // Flush at RUN cycle 10, then hold flush with start high in IDLE
        @(posedge clk); #1;
        funct3 = 3'b000; x1 = 32'd5; x2 = 32'd6; start1 = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_stall_low", 32'(stall1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_busy", 32'(busy1), 32'd0);
        check("flush_done", 32'(done1), 32'd0);
        check("flush_result_kept", result1, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        flush = 1'b0; start1 = 1'b0;
        @(negedge clk);
        check("flush_no_accept", 32'(busy1), 32'd0);
        check("flush_done_after", 32'(done1), 32'd0);
        $display("[TB] flush mid-run handled, result=%08h", result1);
        run_op(1, "mul_5_6", 3'b000, 32'd5, 32'd6, 32'd30, 33, 32, 1'b0, '0, '0);

        // Reset at RUN cycle 20
        @(posedge clk); #1;
        funct3 = 3'b000; x1 = 32'd9; x2 = 32'd9; start1 = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_busy_before", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; start1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_done", 32'(done1), 32'd0);
        check("midrst_result", result1, 32'd0);
        check("midrst_stall", 32'(stall1), 32'd0);
        $display("[TB] reset mid-run handled, result=%08h", result1);

        run_op(1, "mul_3_4_chg", 3'b000, 32'd3, 32'd4, 32'd12, 33, 32, 1'b1, 32'd100, 32'd200);
        run_op(1, "unsupported", 3'b100, 32'd3, 32'd4, 32'd0, 1, 0, 1'b0, '0, '0);
        back_to_back(1, "b2b_bpc1", 34);

        run_op(4, "bpc4_mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 9, 8, 1'b0, '0, '0);
        run_op(4, "bpc4_mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, 8, 1'b0, '0, '0);
        run_op(4, "bpc4_mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 8, 1'b0, '0, '0);
        back_to_back(4, "b2b_bpc4", 10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
